segre_mem_arbiter: RTL and testbench
====================================

// Module: segre_mem_arbiter
// PURPOSE
// - Shares the single main-memory port between I-cache refill and D-cache refill/writeback.
// - One transaction outstanding at a time; 4-state FSM sequences issue, wait and response.
// - Fixed IC>DC priority, with a starvation counter that forces a DC win.
// - Drives sel_mem_req_o for the pipeline controller and the top-level memory muxes.
// PARAMETERS
// ADDR_W        32  address width
// LINE_W        128 cache-line width (rdata/wdata)
// STARVE_LIMIT  4   consecutive IC grants over a waiting DC before DC is forced (>=1)
// PORTS
// clk_i          in  1       clock
// rst_i          in  1       synchronous reset, active-high
// ic_req_i       in  1       IC refill request; held until ic_rvalid_o
// ic_addr_i      in  ADDR_W  IC line address
// ic_gnt_o       out 1       1-cycle pulse: IC transaction issued
// ic_rvalid_o    out 1       1-cycle pulse: IC line returned
// ic_rdata_o     out LINE_W  IC line data, valid with ic_rvalid_o
// dc_req_i       in  1       DC request; held until dc_rvalid_o
// dc_we_i        in  1       1=writeback, 0=refill
// dc_addr_i      in  ADDR_W  DC line address
// dc_wdata_i     in  LINE_W  DC writeback data
// dc_gnt_o       out 1       1-cycle pulse: DC transaction issued
// dc_rvalid_o    out 1       1-cycle pulse: DC read data / write ack
// dc_rdata_o     out LINE_W  DC line data, valid with dc_rvalid_o (don't-care on writes)
// mem_req_o      out 1       1-cycle request to main memory
// mem_we_o       out 1       write enable, valid with mem_req_o
// mem_addr_o     out ADDR_W  address, valid with mem_req_o
// mem_wdata_o    out LINE_W  write data, valid with mem_req_o
// mem_rvalid_i   in  1       memory completion (read data or write ack)
// mem_rdata_i    in  LINE_W  memory read data
// sel_mem_req_o  out 1       0=IC owns or idle, 1=DC owns
// busy_o         out 1       state != ARB_IDLE
// BEHAVIOUR
// - Reset: all outputs 0; state ARB_IDLE; starvation counter 0; owner IC.
// - ARB_IDLE: no req -> stay. Any req -> pick winner, latch its addr/we/wdata and owner -> ARB_ISSUE.
// - Winner: DC if starve_cnt==STARVE_LIMIT and dc_req_i; else IC if ic_req_i; else DC.
// - Starve counter: +1 when IC wins while dc_req_i=1. Clears when DC wins or dc_req_i=0 at arbitration.
//   Saturates at STARVE_LIMIT. Width $clog2(STARVE_LIMIT+1).
// - ARB_ISSUE (1 cycle): mem_req_o=1, mem_we_o/addr/wdata from latches; owner gnt_o=1 -> ARB_WAIT.
// - ARB_WAIT: stay until mem_rvalid_i; then register mem_rdata_i -> ARB_RESP.
// - ARB_RESP (1 cycle): owner rvalid_o=1, owner rdata_o=registered data; other rvalid_o=0 -> ARB_IDLE.
// - Requests are not sampled in ARB_RESP. The requester drops req the cycle after rvalid, so the next IDLE sees the true req.
// - Latency: req seen cycle 0 -> mem_req_o cycle 1; mem_rvalid_i at cycle 1+k (k>=1) -> rvalid_o at cycle 2+k.
// - mem_rvalid_i outside ARB_WAIT is ignored (no state change, no rvalid_o).
// - Changes to req inputs after ARB_IDLE are ignored until return to ARB_IDLE.
// - sel_mem_req_o = owner while busy_o; 0 in ARB_IDLE.
// - rdata_o holds its last value between pulses.
// - Reset mid-transaction: next cycle ARB_IDLE with all outputs 0. The outstanding transaction is abandoned,
//   and a late mem_rvalid_i is ignored.
// STRUCTURE
// - segre_pkg additions: typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP} mem_arb_state_e;
//   localparam MEM_ARB_IC = 1'b0, MEM_ARB_DC = 1'b1.
// - Sub-module segre_arb_starve_counter holds the saturating counter plus its force_dc output.
// - The FSM, latches and output decode stay in this module.
// TESTING
// 1 IC read: ic_req_i=1, ic_addr_i=0x100 @c0; mem_rvalid_i @c4, rdata=0xA5A5..
//   -> mem_req_o=1, we=0, addr=0x100 @c1; ic_gnt_o @c1; ic_rvalid_o=1, rdata=0xA5A5.. @c5; dc_* pulses stay 0.
// 2 Simultaneous IC(0x100) + DC read(0x200) @c0 -> IC issued @c1 with sel=0.
//   After IC resp, DC issued on the next IDLE cycle with sel=1, addr=0x200; dc_rvalid_o on completion.
// 3 Starvation, STARVE_LIMIT=4: IC re-requests every IDLE, DC held high
//   -> exactly 4 IC transactions, then DC wins the 5th arbitration; counter returns to 0.
// 4 DC writeback: dc_we_i=1, addr=0x300, wdata=0xDEADBEEF.. -> mem_req_o with mem_we_o=1 and the same addr/wdata.
//   dc_rvalid_o 1 cycle after mem_rvalid_i; IC req arriving meanwhile is issued only after RESP.
// 5 rst_i=1 in ARB_WAIT -> next cycle busy_o=0, all outputs 0.
//   mem_rvalid_i pulse 2 cycles later -> no rvalid_o, state stays ARB_IDLE.
// 6 Spurious mem_rvalid_i in ARB_IDLE and ARB_ISSUE -> ignored.
//   The transaction still completes only on the first mem_rvalid_i seen in ARB_WAIT.

Source files
------------

// File: rtl/segre_pkg.sv
`default_nettype none
// ============================================================================
// segre_pkg: shared types and constants for the segre memory arbiter
// Revision: 1.0
// ============================================================================
package segre_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } mem_arb_state_e;

  localparam logic MEM_ARB_IC = 1'b0;
  localparam logic MEM_ARB_DC = 1'b1;

  // IC has fixed priority unless the starvation counter forces a waiting DC through.
  function automatic logic pick_owner(input logic force_dc, input logic ic_req, input logic dc_req);
    if (force_dc && dc_req) return MEM_ARB_DC;
    if (ic_req) return MEM_ARB_IC;
    return MEM_ARB_DC;
  endfunction

endpackage
`default_nettype wire

// File: rtl/segre_arb_starve_counter.sv
`default_nettype none
// ============================================================================
// segre_arb_starve_counter: counts consecutive IC wins over a waiting DC
// Revision: 1.0
// ============================================================================
module segre_arb_starve_counter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic arb_en,
  input  logic ic_won,
  input  logic dc_req,
  output logic force_dc
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (arb_en) begin
      if (ic_won && dc_req) begin
        if (count != LIMIT) count <= count + CNT_W'(1);
      end else begin
        count <= '0;
      end
    end
  end

  assign force_dc = (count == LIMIT);

endmodule
`default_nettype wire

// File: rtl/segre_mem_arbiter.sv
`default_nettype none
// ============================================================================
// segre_mem_arbiter: shares one main-memory port between IC refill and DC refill/writeback
// Revision: 1.0
// ============================================================================
module segre_mem_arbiter
  import segre_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int LINE_W       = 128,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ic_req_i,
  input  logic [ADDR_W-1:0] ic_addr_i,
  output logic              ic_gnt_o,
  output logic              ic_rvalid_o,
  output logic [LINE_W-1:0] ic_rdata_o,
  input  logic              dc_req_i,
  input  logic              dc_we_i,
  input  logic [ADDR_W-1:0] dc_addr_i,
  input  logic [LINE_W-1:0] dc_wdata_i,
  output logic              dc_gnt_o,
  output logic              dc_rvalid_o,
  output logic [LINE_W-1:0] dc_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_wdata_o,
  input  logic              mem_rvalid_i,
  input  logic [LINE_W-1:0] mem_rdata_i,
  output logic              sel_mem_req_o,
  output logic              busy_o
);

  mem_arb_state_e    state, state_next;
  logic              owner;
  logic              win_owner;
  logic              ic_won;
  logic              arb_en;
  logic              force_dc;
  logic              issue;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic [LINE_W-1:0] ic_rdata_q;
  logic [LINE_W-1:0] dc_rdata_q;

  assign win_owner = pick_owner(force_dc, ic_req_i, dc_req_i);
  assign ic_won    = (win_owner == MEM_ARB_IC);

  segre_arb_starve_counter #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk      (clk_i),
    .rst      (rst_i),
    .arb_en   (arb_en),
    .ic_won   (ic_won),
    .dc_req   (dc_req_i),
    .force_dc (force_dc)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= ARB_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    arb_en      = 1'b0;
    ic_gnt_o    = 1'b0;
    dc_gnt_o    = 1'b0;
    ic_rvalid_o = 1'b0;
    dc_rvalid_o = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (ic_req_i || dc_req_i) begin
          arb_en     = 1'b1;
          state_next = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        ic_gnt_o   = (owner == MEM_ARB_IC);
        dc_gnt_o   = (owner == MEM_ARB_DC);
        state_next = ARB_WAIT;
      end
      ARB_WAIT: begin
        if (mem_rvalid_i) state_next = ARB_RESP;
      end
      ARB_RESP: begin
        ic_rvalid_o = (owner == MEM_ARB_IC);
        dc_rvalid_o = (owner == MEM_ARB_DC);
        state_next  = ARB_IDLE;
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  // Request fields are frozen at arbitration; later input changes are ignored.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owner      <= MEM_ARB_IC;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ic_rdata_q <= '0;
      dc_rdata_q <= '0;
    end else begin
      if (arb_en) begin
        owner   <= win_owner;
        we_q    <= (win_owner == MEM_ARB_DC) && dc_we_i;
        addr_q  <= (win_owner == MEM_ARB_DC) ? dc_addr_i : ic_addr_i;
        wdata_q <= (win_owner == MEM_ARB_DC) ? dc_wdata_i : '0;
      end
      if ((state == ARB_WAIT) && mem_rvalid_i) begin
        if (owner == MEM_ARB_DC) dc_rdata_q <= mem_rdata_i;
        else                     ic_rdata_q <= mem_rdata_i;
      end
    end
  end

  assign issue         = (state == ARB_ISSUE);
  assign mem_req_o     = issue;
  assign mem_we_o      = issue & we_q;
  assign mem_addr_o    = issue ? addr_q : '0;
  assign mem_wdata_o   = issue ? wdata_q : '0;
  assign ic_rdata_o    = ic_rdata_q;
  assign dc_rdata_o    = dc_rdata_q;
  assign busy_o        = (state != ARB_IDLE);
  assign sel_mem_req_o = busy_o & owner;

endmodule
`default_nettype wire

// File: tb/tb_segre_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_segre_mem_arbiter: randomized scoreboard bench for segre_mem_arbiter
// Revision: 1.0
// ============================================================================
module tb_segre_mem_arbiter;

  localparam int ADDR_W       = 32;
  localparam int LINE_W       = 128;
  localparam int STARVE_LIMIT = 4;
  localparam int NCYC         = 4000;
  localparam int DRAIN        = 60;
  localparam int NEVER        = 32'h7fffffff;

  logic              clk = 1'b0;
  logic              rst_i = 1'b1;
  logic              ic_req_i = 1'b0;
  logic [ADDR_W-1:0] ic_addr_i = '0;
  logic              ic_gnt_o, ic_rvalid_o;
  logic [LINE_W-1:0] ic_rdata_o;
  logic              dc_req_i = 1'b0;
  logic              dc_we_i = 1'b0;
  logic [ADDR_W-1:0] dc_addr_i = '0;
  logic [LINE_W-1:0] dc_wdata_i = '0;
  logic              dc_gnt_o, dc_rvalid_o;
  logic [LINE_W-1:0] dc_rdata_o;
  logic              mem_req_o, mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [LINE_W-1:0] mem_wdata_o;
  logic              mem_rvalid_i = 1'b0;
  logic [LINE_W-1:0] mem_rdata_i = '0;
  logic              sel_mem_req_o, busy_o;

  segre_mem_arbiter #(
    .ADDR_W(ADDR_W), .LINE_W(LINE_W), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .ic_req_i(ic_req_i), .ic_addr_i(ic_addr_i), .ic_gnt_o(ic_gnt_o),
    .ic_rvalid_o(ic_rvalid_o), .ic_rdata_o(ic_rdata_o),
    .dc_req_i(dc_req_i), .dc_we_i(dc_we_i), .dc_addr_i(dc_addr_i), .dc_wdata_i(dc_wdata_i),
    .dc_gnt_o(dc_gnt_o), .dc_rvalid_o(dc_rvalid_o), .dc_rdata_o(dc_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .sel_mem_req_o(sel_mem_req_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // One memory transaction as the reference model expects to see it.
  typedef struct {
    logic              owner;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
    logic [LINE_W-1:0] rdata;
    int                issue_cyc;
    int                mrv_cyc;
    int                resp_cyc;
  } txn_t;

  txn_t issue_q[$];
  txn_t resp_q[$];

  int   vectors = 0;
  int   miscompares = 0;
  int   exp_busy_from = 1;
  int   exp_busy_to = 0;
  logic exp_owner = 1'b0;
  int   rst_cyc = 2;
  logic [LINE_W-1:0] last_ic = '0;
  logic [LINE_W-1:0] last_dc = '0;
  bit   dc_known = 1'b1;

  task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      if (miscompares <= 40)
        $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Monitor: compares whatever the DUT presents this cycle against the queue heads.
  task automatic monitor_cycle();
    txn_t t;
    txn_t r;
    logic exp_req, exp_rv, exp_busy;
    t = '{default: '0};
    r = '{default: '0};
    if (cyc == rst_cyc + 1) begin
      last_ic  = '0;
      last_dc  = '0;
      dc_known = 1'b1;
      check("reset_ctrl", 128'({ic_gnt_o, ic_rvalid_o, dc_gnt_o, dc_rvalid_o, mem_req_o,
                                mem_we_o, sel_mem_req_o, busy_o, mem_addr_o}), '0);
      check("reset_wdata", mem_wdata_o, '0);
    end

    exp_busy = (cyc >= exp_busy_from) && (cyc <= exp_busy_to);
    check("busy", 128'(busy_o), 128'(exp_busy));
    check("sel", 128'(sel_mem_req_o), 128'(exp_busy && exp_owner));

    exp_req = (issue_q.size() > 0) && (issue_q[0].issue_cyc == cyc);
    if (exp_req) t = issue_q.pop_front();
    check("mem_req", 128'(mem_req_o), 128'(exp_req));
    check("ic_gnt", 128'(ic_gnt_o), 128'(exp_req && !t.owner));
    check("dc_gnt", 128'(dc_gnt_o), 128'(exp_req && t.owner));
    if (exp_req && mem_req_o) begin
      check("mem_we", 128'(mem_we_o), 128'(t.we));
      check("mem_addr", 128'(mem_addr_o), 128'(t.addr));
      if (t.we) check("mem_wdata", mem_wdata_o, t.wdata);
    end

    exp_rv = (resp_q.size() > 0) && (resp_q[0].resp_cyc == cyc);
    if (exp_rv) begin
      r = resp_q.pop_front();
      if (!r.owner) last_ic = r.rdata;
      else if (!r.we) begin
        last_dc  = r.rdata;
        dc_known = 1'b1;
      end else dc_known = 1'b0;
    end
    check("ic_rvalid", 128'(ic_rvalid_o), 128'(exp_rv && !r.owner));
    check("dc_rvalid", 128'(dc_rvalid_o), 128'(exp_rv && r.owner));
    check("ic_rdata", ic_rdata_o, last_ic);
    if (dc_known) check("dc_rdata", dc_rdata_o, last_dc);
  endtask

  always @(negedge clk) begin
    if (cyc >= 3) monitor_cycle();
  end

  // Requester agents, memory responder and reference arbitration model.
  logic              ic_act = 1'b0, dc_act = 1'b0;
  logic [ADDR_W-1:0] ic_a = '0, dc_a = '0;
  logic              dc_w = 1'b0;
  logic [LINE_W-1:0] dc_wd = '0;
  int                ic_done = NEVER, dc_done = NEVER;
  txn_t              cur;
  bit                cur_valid = 1'b0;
  int                free_at = 3;
  int                starve = 0;
  int                hold_until = 0;
  int                late_rv_cyc = -1;
  int                resets_done = 0;

  initial begin
    int   c;
    int   p_ic, p_dc, p_sp;
    int   k;
    logic own;
    bit   do_rst;
    cur = '{default: '0};
    for (int n = 0; n < NCYC; n++) begin
      @(posedge clk);
      #1;
      c = cyc;
      if (c < 3) continue;

      if (c < 1200)              begin p_ic = 50;  p_dc = 50;  p_sp = 10; end
      else if (c < 2200)         begin p_ic = 100; p_dc = 100; p_sp = 5;  end
      else if (c < 3200)         begin p_ic = 20;  p_dc = 30;  p_sp = 30; end
      else if (c < NCYC - DRAIN) begin p_ic = 70;  p_dc = 40;  p_sp = 15; end
      else                       begin p_ic = 0;   p_dc = 0;   p_sp = 0;  end

      // Occasionally reset while a transaction is waiting on memory.
      do_rst = cur_valid && (c > cur.issue_cyc) && (c < cur.mrv_cyc) && (resets_done < 4) &&
               (c > 200) && (c < NCYC - DRAIN) && ($urandom_range(99, 0) < 10);
      if (do_rst) begin
        resets_done++;
        rst_i        = 1'b1;
        issue_q.delete();
        resp_q.delete();
        cur_valid    = 1'b0;
        exp_busy_to  = c;
        free_at      = c + 1;
        starve       = 0;
        ic_act       = 1'b0;
        dc_act       = 1'b0;
        hold_until   = c + 4;
        late_rv_cyc  = c + 2;
        rst_cyc      = c;
        ic_req_i     = 1'b0;
        dc_req_i     = 1'b0;
        mem_rvalid_i = 1'b0;
        continue;
      end
      rst_i = 1'b0;

      if (ic_act && c > ic_done) ic_act = 1'b0;
      if (dc_act && c > dc_done) dc_act = 1'b0;
      if (c > hold_until) begin
        if (!ic_act && $urandom_range(99, 0) < p_ic) begin
          ic_act  = 1'b1;
          ic_a    = $urandom;
          ic_done = NEVER;
        end
        if (!dc_act && $urandom_range(99, 0) < p_dc) begin
          dc_act  = 1'b1;
          dc_a    = $urandom;
          dc_w    = 1'($urandom_range(1, 0));
          dc_wd   = rnd128();
          dc_done = NEVER;
        end
      end
      ic_req_i   = ic_act;
      ic_addr_i  = ic_act ? ic_a : $urandom;
      dc_req_i   = dc_act;
      dc_addr_i  = dc_act ? dc_a : $urandom;
      dc_we_i    = dc_act ? dc_w : 1'($urandom_range(1, 0));
      dc_wdata_i = dc_act ? dc_wd : rnd128();

      // Memory: real completion, the post-reset stray pulse, or noise outside the wait window.
      if (cur_valid && c == cur.mrv_cyc) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = cur.rdata;
      end else if (c == late_rv_cyc) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = rnd128();
      end else if (!(cur_valid && c > cur.issue_cyc && c <= cur.mrv_cyc) &&
                   ($urandom_range(99, 0) < p_sp)) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = rnd128();
      end else begin
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = rnd128();
      end

      // Arbitration whenever the port is free and somebody is asking.
      if (c >= free_at && (ic_act || dc_act)) begin
        if (starve == STARVE_LIMIT && dc_act) own = 1'b1;
        else if (ic_act)                      own = 1'b0;
        else                                  own = 1'b1;
        if (!own && dc_act) starve = (starve + 1 > STARVE_LIMIT) ? STARVE_LIMIT : starve + 1;
        else                starve = 0;
        k             = $urandom_range(4, 1);
        cur.owner     = own;
        cur.we        = own ? dc_w : 1'b0;
        cur.addr      = own ? dc_a : ic_a;
        cur.wdata     = own ? dc_wd : '0;
        cur.rdata     = rnd128();
        cur.issue_cyc = c + 1;
        cur.mrv_cyc   = c + 1 + k;
        cur.resp_cyc  = c + 2 + k;
        cur_valid     = 1'b1;
        issue_q.push_back(cur);
        resp_q.push_back(cur);
        free_at       = c + 3 + k;
        exp_busy_from = c + 1;
        exp_busy_to   = c + 2 + k;
        exp_owner     = own;
        if (own) dc_done = c + 2 + k;
        else     ic_done = c + 2 + k;
      end
    end

    @(negedge clk);
    check("issue_q_drained", 128'(issue_q.size()), '0);
    check("resp_q_drained", 128'(resp_q.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
